multicycle_alu: RTL and testbench

- Parametrised, sequential successor to the datapath's single-cycle ALU.
- Runs all eight existing integer ops plus right shifts, and iterative multiply/divide, under a start/busy/done handshake.
- Sits in the EXE stage of the multi-cycle CPU. The control unit holds the EXE state until done; HI/LO writeback takes result_hi/result.

---
 rtl/multicycle_alu_if.sv | 46 ++++
 rtl/multicycle_alu.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Start/busy/done handshake and operand bus of multicycle_alu.
// Defining ALU_OVERFLOW_DETECT_EN adds the registered signed-overflow flag.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [3:0]       ALUop;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic [WIDTH-1:0] Ext;
    logic [SHW-1:0]   Sa;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             sign;

`ifdef ALU_OVERFLOW_DETECT_EN
    logic             overflow;

    modport master (
        output start, ALUop, ALUSrcA, ALUSrcB, ReadData1, ReadData2, Ext, Sa,
        input  busy, done, Result, result_hi, zero, sign, overflow
    );

    modport slave (
        input  start, ALUop, ALUSrcA, ALUSrcB, ReadData1, ReadData2, Ext, Sa,
        output busy, done, Result, result_hi, zero, sign, overflow
    );
`else
    modport master (
        output start, ALUop, ALUSrcA, ALUSrcB, ReadData1, ReadData2, Ext, Sa,
        input  busy, done, Result, result_hi, zero, sign
    );

    modport slave (
        input  start, ALUop, ALUSrcA, ALUSrcB, ReadData1, ReadData2, Ext, Sa,
        output busy, done, Result, result_hi, zero, sign
    );
`endif
endinterface

// File: rtl/multicycle_alu.sv
// Sequential EXE-stage ALU: single-cycle integer ops plus iterative mult/div.
// Optional macro ALU_OVERFLOW_DETECT_EN adds the registered add/sub overflow flag.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            Reset,
    multicycle_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_resultHi;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic             r_neg;
    logic             r_negRem;
    logic [SHW-1:0]   r_count;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SHW-1:0]   w_shamt;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_isSigned;
    logic             w_divByZero;
    logic             w_launch;
    logic             w_lastIter;
    logic             w_finish;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_simple;

    assign w_a         = bus.ALUSrcA ? {{(WIDTH-SHW){1'b0}}, bus.Sa} : bus.ReadData1;
    assign w_b         = bus.ALUSrcB ? bus.Ext : bus.ReadData2;
    assign w_shamt     = w_a[SHW-1:0];
    assign w_isMul     = (bus.ALUop[3:1] == 3'b101);
    assign w_isDiv     = (bus.ALUop[3:1] == 3'b110);
    assign w_isSigned  = bus.ALUop[0];
    assign w_divByZero = (w_b == '0);
    assign w_launch    = (r_state == IDLE) && bus.start;
    assign w_lastIter  = (r_count == SHW'(WIDTH-1));
    assign w_finish    = ((r_state == MUL) || (r_state == DIV)) && w_lastIter;

    // Mult and div iterate on magnitudes; signs are reapplied on the last step.
    assign w_aNeg = w_isSigned && w_a[WIDTH-1];
    assign w_bNeg = w_isSigned && w_b[WIDTH-1];
    assign w_aMag = w_aNeg ? -w_a : w_a;
    assign w_bMag = w_bNeg ? -w_b : w_b;
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;

    always_comb begin
        w_simple = '0;
        case (bus.ALUop)
            4'b0000: w_simple = w_sum;
            4'b0001: w_simple = w_diff;
            4'b0010: w_simple = w_b << w_shamt;
            4'b0011: w_simple = w_a | w_b;
            4'b0100: w_simple = w_a & w_b;
            4'b0101: w_simple = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            4'b0110: w_simple = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            4'b0111: w_simple = w_a ^ w_b;
            4'b1000: w_simple = w_b >> w_shamt;
            4'b1001: w_simple = $signed(w_b) >>> w_shamt;
            default: w_simple = '0;
        endcase
    end

    // Shift-add step: {r_hi, r_lo} holds partial product over remaining multiplier bits.
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [2*WIDTH-1:0] w_mulFinal;

    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mulNext  = {w_mulSum, r_lo[WIDTH-1:1]};
    assign w_mulFinal = r_neg ? -w_mulNext : w_mulNext;

    // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH:0]   w_divTrial;
    logic             w_qBit;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quotNext;
    logic [WIDTH-1:0] w_quotFinal;
    logic [WIDTH-1:0] w_remFinal;

    assign w_divShift  = {r_hi, r_lo[WIDTH-1]};
    assign w_divTrial  = w_divShift - {1'b0, r_mcand};
    assign w_qBit      = ~w_divTrial[WIDTH];
    assign w_remNext   = w_qBit ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
    assign w_quotNext  = {r_lo[WIDTH-2:0], w_qBit};
    assign w_quotFinal = r_neg ? -w_quotNext : w_quotNext;
    assign w_remFinal  = r_negRem ? -w_remNext : w_remNext;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_isMul) begin
                        w_nextState = MUL;
                    end else if (w_isDiv && !w_divByZero) begin
                        w_nextState = DIV;
                    end else begin
                        w_nextState = DONE;
                    end
                end
            end
            MUL, DIV: begin
                w_busy = 1'b1;
                if (w_lastIter) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_result   <= '0;
            r_resultHi <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mcand    <= '0;
            r_neg      <= 1'b0;
            r_negRem   <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_count  <= '0;
                        r_hi     <= '0;
                        r_neg    <= w_aNeg ^ w_bNeg;
                        r_negRem <= w_aNeg;
                        r_mcand  <= w_isMul ? w_aMag : w_bMag;
                        r_lo     <= w_isMul ? w_bMag : w_aMag;
                        if (w_nextState == DONE) begin
                            if (w_isDiv) begin
                                r_result   <= '1;
                                r_resultHi <= w_a;
                            end else begin
                                r_result   <= w_simple;
                                r_resultHi <= '0;
                            end
                        end
                    end
                end
                MUL: begin
                    r_count       <= r_count + SHW'(1);
                    {r_hi, r_lo}  <= w_mulNext;
                    if (w_lastIter) begin
                        r_result   <= w_mulFinal[WIDTH-1:0];
                        r_resultHi <= w_mulFinal[2*WIDTH-1:WIDTH];
                    end
                end
                DIV: begin
                    r_count <= r_count + SHW'(1);
                    r_hi    <= w_remNext;
                    r_lo    <= w_quotNext;
                    if (w_lastIter) begin
                        r_result   <= w_quotFinal;
                        r_resultHi <= w_remFinal;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_OVERFLOW_DETECT_EN
    // Overflow when the operands' effective signs agree but the result's sign differs.
    logic w_addOvf;
    logic w_subOvf;
    logic r_overflow;

    assign w_addOvf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_subOvf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else if (w_launch && (w_nextState == DONE)) begin
            r_overflow <= ((bus.ALUop == 4'b0000) && w_addOvf) ||
                          ((bus.ALUop == 4'b0001) && w_subOvf);
        end else if (w_finish) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.overflow = r_overflow;
`endif

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.Result    = r_result;
    assign bus.result_hi = r_resultHi;
    assign bus.zero      = (r_result == '0);
    assign bus.sign      = r_result[WIDTH-1];
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expected results are queued at start and popped at done.
// Overflow flag checks are compiled in when ALU_OVERFLOW_DETECT_EN is defined.
module tb_multicycle_alu;
    localparam int W   = 32;
    localparam int SHW = $clog2(W);

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        logic [7:0]   lat;
    } exp_t;

    logic CLK = 1'b0;
    logic Reset;
    int   checkCount = 0;
    int   failCount  = 0;
    exp_t scoreboard[$];

    always #5 CLK = ~CLK;

    multicycle_alu_if #(.WIDTH(W)) bus ();
    multicycle_alu #(.WIDTH(W)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    multicycle_alu_if #(.WIDTH(16)) bus16 ();
    multicycle_alu #(.WIDTH(16)) dut16 (.CLK(CLK), .Reset(Reset), .bus(bus16));

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [2*W-1:0] modelResult(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0]      wide;
        logic signed [W-1:0] sA;
        logic signed [W-1:0] sB;
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        int                  sh;
        sh = int'(a[SHW-1:0]);
        case (op)
            4'd0:  return {{W{1'b0}}, a + b};
            4'd1:  return {{W{1'b0}}, a - b};
            4'd2:  return {{W{1'b0}}, b << sh};
            4'd3:  return {{W{1'b0}}, a | b};
            4'd4:  return {{W{1'b0}}, a & b};
            4'd5:  return {{(2*W-1){1'b0}}, (a < b)};
            4'd6:  return {{(2*W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd7:  return {{W{1'b0}}, a ^ b};
            4'd8:  return {{W{1'b0}}, b >> sh};
            4'd9: begin
                wide = {{W{b[W-1]}}, b} >> sh;
                return {{W{1'b0}}, wide[W-1:0]};
            end
            4'd10: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            4'd11: return {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            4'd12: begin
                if (b == '0) return {a, {W{1'b1}}};
                return {a % b, a / b};
            end
            4'd13: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) return {{W{1'b0}}, a};
                sA = a;
                sB = b;
                q  = sA / sB;
                r  = sA % sB;
                return {r, q};
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic modelOverflow(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        if (op == 4'd0) s = {a[W-1], a} + {b[W-1], b};
        else if (op == 4'd1) s = {a[W-1], a} - {b[W-1], b};
        else return 1'b0;
        return s[W] != s[W-1];
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                                 input logic [W-1:0] ext, input logic [SHW-1:0] sa, input logic srcA, input logic srcB);
        exp_t           e;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] r;
        a     = srcA ? W'(sa) : rd1;
        b     = srcB ? ext : rd2;
        r     = modelResult(op, a, b);
        e.lo  = r[W-1:0];
        e.hi  = r[2*W-1:W];
        e.ovf = modelOverflow(op, a, b);
        e.lat = ((op[3:1] == 3'b101) || (op[3:1] == 3'b110 && b != '0)) ? 8'(W + 1) : 8'd1;
        scoreboard.push_back(e);
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.ALUop     = op;
        bus.ReadData1 = rd1;
        bus.ReadData2 = rd2;
        bus.Ext       = ext;
        bus.Sa        = sa;
        bus.ALUSrcA   = srcA;
        bus.ALUSrcB   = srcB;
        @(posedge CLK);
        #1;
        bus.start     = 1'b0;
        bus.ALUop     = 4'($urandom);
        bus.ReadData1 = $urandom;
        bus.ReadData2 = $urandom;
        bus.Ext       = $urandom;
        bus.Sa        = SHW'($urandom);
        bus.ALUSrcA   = 1'($urandom);
        bus.ALUSrcB   = 1'($urandom);
    endtask

    task automatic collectResult(input string tag);
        exp_t e;
        int   cyc;
        bit   seen;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, ".queue"}, 64'd0, 64'd1);
            return;
        end
        e    = scoreboard.pop_front();
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3 * W) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) checkOutput({tag, ".busy"}, 64'(bus.busy), 64'(e.lat != 8'd1));
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
            return;
        end
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(e.lat));
        checkOutput({tag, ".Result"}, 64'(bus.Result), 64'(e.lo));
        checkOutput({tag, ".result_hi"}, 64'(bus.result_hi), 64'(e.hi));
        checkOutput({tag, ".zero"}, 64'(bus.zero), 64'(e.lo == '0));
        checkOutput({tag, ".sign"}, 64'(bus.sign), 64'(e.lo[W-1]));
`ifdef ALU_OVERFLOW_DETECT_EN
        checkOutput({tag, ".overflow"}, 64'(bus.overflow), 64'(e.ovf));
`endif
        @(negedge CLK);
        checkOutput({tag, ".donePulse"}, 64'(bus.done), 64'd0);
        checkOutput({tag, ".hold"}, 64'(bus.Result), 64'(e.lo));
    endtask

    task automatic runOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        applyStimulus(op, a, b, '0, '0, 1'b0, 1'b0);
        collectResult(tag);
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (bus.done === 1'b1) n++;
        end
    endtask

    initial begin
        #200us;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int             n;
        int             cyc;
        logic [31:0]    p16;
        Reset = 1'b1;
        bus.start = 1'b0;   bus.ALUop = '0;     bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
        bus.ReadData1 = '0; bus.ReadData2 = '0; bus.Ext = '0;       bus.Sa = '0;
        bus16.start = 1'b0; bus16.ALUop = '0;   bus16.ALUSrcA = 1'b0; bus16.ALUSrcB = 1'b0;
        bus16.ReadData1 = '0; bus16.ReadData2 = '0; bus16.Ext = '0; bus16.Sa = '0;
        repeat (3) @(negedge CLK);
        checkOutput("reset.busy", 64'(bus.busy), 64'd0);
        checkOutput("reset.done", 64'(bus.done), 64'd0);
        checkOutput("reset.Result", 64'(bus.Result), 64'd0);
        checkOutput("reset.result_hi", 64'(bus.result_hi), 64'd0);
        checkOutput("reset.zero", 64'(bus.zero), 64'd1);
        checkOutput("reset.sign", 64'(bus.sign), 64'd0);
`ifdef ALU_OVERFLOW_DETECT_EN
        checkOutput("reset.overflow", 64'(bus.overflow), 64'd0);
`endif
        Reset = 1'b0;

        runOp(4'b0000, 32'h7FFF_FFFF, 32'h1, "add.wrap");

        // Abort a signed multiply ten cycles in; no done may follow.
        @(negedge CLK);
        bus.start = 1'b1; bus.ALUop = 4'b1011; bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
        bus.ReadData1 = 32'hFFFF_FFFD; bus.ReadData2 = 32'd7;
        @(posedge CLK);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        checkOutput("rstmul.busyBefore", 64'(bus.busy), 64'd1);
        #1 Reset = 1'b1;
        #1;
        checkOutput("rstmul.busy", 64'(bus.busy), 64'd0);
        checkOutput("rstmul.done", 64'(bus.done), 64'd0);
        checkOutput("rstmul.Result", 64'(bus.Result), 64'd0);
        checkOutput("rstmul.zero", 64'(bus.zero), 64'd1);
        @(negedge CLK);
        Reset = 1'b0;
        countDones(2 * W, n);
        checkOutput("rstmul.noDone", 64'(n), 64'd0);
        runOp(4'b0000, 32'd20, 32'd22, "add.afterReset");

        runOp(4'b0001, 32'd5, 32'd5, "sub.zero");
        runOp(4'b1001, 32'd4, 32'h8000_0000, "sra");
        runOp(4'b1000, 32'd4, 32'h8000_0000, "srl");
        runOp(4'b0110, 32'hFFFF_FFFF, 32'd1, "slt");
        runOp(4'b0101, 32'hFFFF_FFFF, 32'd1, "sltu");
        runOp(4'b0011, 32'hF0F0_0000, 32'h0000_0F0F, "or");
        runOp(4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, "and");
        runOp(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, "reserved");
        applyStimulus(4'b0010, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h11, SHW'(3), 1'b1, 1'b1);
        collectResult("sll.saExt");

        runOp(4'b1011, 32'hFFFF_FFFD, 32'd7, "mult.neg");
        runOp(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu.max");
        runOp(4'b1011, 32'h8000_0000, 32'h8000_0000, "mult.minmin");
        runOp(4'b1101, 32'hFFFF_FFF9, 32'd2, "div.neg");
        runOp(4'b1101, 32'd7, 32'hFFFF_FFFE, "div.negDivisor");
        runOp(4'b1100, 32'd100, 32'd0, "divu.zero");
        runOp(4'b1101, 32'hFFFF_FFF9, 32'd0, "div.zero");
        runOp(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, "div.ovf");
        runOp(4'b1100, 32'hFFFF_FFFF, 32'd3, "divu.big");
        runOp(4'b0000, 32'd1, 32'd1, "add.small");
        runOp(4'b0001, 32'h8000_0000, 32'd1, "sub.ovf");

        // Starts during DIV must be dropped; only the original divu completes.
        applyStimulus(4'b1100, 32'd1000, 32'd7, '0, '0, 1'b0, 1'b0);
        fork
            collectResult("divu.busyStart");
            begin
                repeat (5) begin
                    @(negedge CLK);
                    #1;
                    bus.start = 1'b1; bus.ALUop = 4'b0000;
                    bus.ReadData1 = $urandom; bus.ReadData2 = $urandom;
                    @(negedge CLK);
                    #1 bus.start = 1'b0;
                end
            end
        join
        countDones(2 * W, n);
        checkOutput("divu.busyStart.extraDone", 64'(n), 64'd0);

        // A start presented in the DONE cycle is dropped as well.
        applyStimulus(4'b0111, 32'hAAAA_5555, 32'h0F0F_0F0F, '0, '0, 1'b0, 1'b0);
        fork
            collectResult("xor.doneStart");
            begin
                @(negedge CLK);
                #1;
                bus.start = 1'b1; bus.ALUop = 4'b0000; bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
                @(negedge CLK);
                #1 bus.start = 1'b0;
            end
        join
        countDones(8, n);
        checkOutput("xor.doneStart.extraDone", 64'(n), 64'd0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0]   op;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 4 == 0) ? W'($urandom_range(0, 3)) : $urandom;
            runOp(op, ra, rb, "random");
        end

        // 16-bit instance: signed multiply, expected product computed at 32 bits.
        p16 = 32'h0000_00FF * 32'h0000_0101;
        @(negedge CLK);
        bus16.start = 1'b1; bus16.ALUop = 4'b1011;
        bus16.ReadData1 = 16'h00FF; bus16.ReadData2 = 16'h0101;
        @(posedge CLK);
        #1;
        bus16.start = 1'b0; bus16.ReadData1 = 16'h1234; bus16.ReadData2 = 16'h4321;
        cyc = 0;
        while (cyc < 64 && bus16.done !== 1'b1) begin
            @(negedge CLK);
            cyc++;
        end
        checkOutput("w16.mult.latency", 64'(cyc), 64'd17);
        checkOutput("w16.mult.Result", 64'(bus16.Result), 64'(p16[15:0]));
        checkOutput("w16.mult.result_hi", 64'(bus16.result_hi), 64'(p16[31:16]));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
